elastic_pipe_line: RTL and testbench
====================================

// Module: elastic_pipe_line
// PURPOSE
//  Parametrised, stallable register pipeline: WIDTH-bit data plus valid flag through DEPTH stages.
//  Each stage has a valid/ready handshake and collapses bubbles.
//  Used between datapath blocks to add registered latency without losing data under backpressure.
//  Includes a synchronous flush for pipeline kill on branch/redirect.
// PARAMETERS
//  WIDTH   8   data width in bits (>=1)
//  DEPTH   3   number of register stages = latency in cycles when unstalled (>=1)
// PORTS
//  clk        in   1               single clock; all state updates on posedge clk
//  rst        in   1               synchronous, active-high reset
//  flush      in   1               synchronous kill of all in-flight entries
//  in_valid   in   1               upstream presents in_data
//  in_ready   out  1               pipe accepts in_data this cycle
//  in_data    in   WIDTH           upstream data
//  out_valid  out  1               last stage holds a valid entry
//  out_ready  in   1               downstream accepts out_data this cycle
//  out_data   out  WIDTH           last-stage data
//  occupancy  out  $clog2(DEPTH+1) count of valid stages
// BEHAVIOUR
//  - Reset: one clock, one reset. rst is synchronous, active-high. Sampled only on posedge clk.
//    While rst=1, the next edge clears every stage valid to 0. out_valid=0, occupancy=0.
//    in_ready=0 while rst is asserted. out_data is 0 after reset (data regs also cleared).
//  - Stage i (0=input side, DEPTH-1=output side) holds v[i], d[i].
//  - Advance rule: adv[DEPTH-1] = out_ready | ~v[DEPTH-1]; adv[i] = adv[i+1] | ~v[i].
//    When adv[i]=1, stage i loads from stage i-1 (stage 0 loads in_valid/in_data).
//    When adv[i]=0, stage i holds.
//  - in_ready = adv[0] & ~flush & ~rst. This is a combinational path from out_ready; it is accepted.
//  - Transfer on each side occurs when valid & ready are both 1 at a posedge.
//  - Latency: an entry accepted at edge N appears with out_valid=1 after edge N+DEPTH-1.
//    This holds when no stall occurs. It is DEPTH register stages from in_data to out_data.
//  - Throughput: 1 entry/cycle while out_ready=1. Data order is strictly preserved (FIFO order).
//  - Bubbles: an invalid stage always accepts from upstream, even if downstream is stalled.
//    Pipe capacity is DEPTH entries.
//  - Full: all v=1 and out_ready=0 -> in_ready=0. Every stage holds its data unchanged.
//  - Full with out_ready=1: simultaneous pop and push in the same cycle. occupancy is unchanged.
//  - Empty: out_valid=0. out_data holds its last value (don't-care to consumers).
//  - Flush=1: the next edge clears all v to 0. Any in-flight input is dropped (in_ready=0).
//    The output transfer in the flush cycle still completes if out_valid & out_ready.
//    Data registers are unchanged by flush.
//  - rst and flush both 1: rst wins. The result is identical apart from the data registers being cleared.
//  - Reset mid-operation: all entries are lost. No output transfer is reported after that edge.
//  - Data registers update only when their stage advances.
//    Held data must be bit-stable while v=1 and stalled.
//  - occupancy = popcount(v), registered state. It changes by at most +1/-1 per cycle.
//    An exception: it drops to 0 on flush/rst.
// STRUCTURE
//  - No shared package is needed. If the datapath package exists, add the clog2-based COUNT_W helper there.
//  - One sub-module: pipe_stage (WIDTH param). Ports: clk, rst, clr (flush), ld, vin, din, vout, dout.
//    pipe_stage is instantiated DEPTH times via generate. Advance chain and occupancy live in the top level.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, occupancy=0, in_ready=0, out_data=0.
//  2. Streaming: DEPTH=3, push 0x01..0x0A back-to-back, out_ready=1.
//     -> 0x01 seen 3 cycles after its accept. All 10 values appear in order with no gaps.
//  3. Backpressure: fill with 0xA1,0xA2,0xA3 with out_ready=0 -> occupancy=3, in_ready=0, out_data=0xA3? no:
//     out_data=0xA1 and stable. Then raise out_ready -> pop 0xA1,0xA2,0xA3 in order.
//  4. Bubble collapse: push 0x11, idle 2 cycles, push 0x22 while out_ready=0.
//     -> both are held, occupancy=2, no loss.
//  5. Flush: occupancy=3, out_valid=1, out_ready=1, flush=1, in_valid=1 (0x55).
//     -> the head pops. Next cycle occupancy=0, 0x55 is never output.
//  6. Parameter sweep: WIDTH=1/DEPTH=1 and WIDTH=32/DEPTH=8.
//     -> random valid/ready scoreboard. Order holds, latency is DEPTH when unstalled, no drop/dup.

Source files
------------

// File: rtl/elastic_pipe_line_pkg.sv
// Shared definitions for the elastic pipeline.
//   count_w(depth) : width of a counter that must hold 0..depth inclusive.
package elastic_pipe_line_pkg;

    function automatic int count_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_line_stage.sv
// One register stage of the elastic pipeline: a valid bit plus WIDTH data bits.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (clears valid and data)
//   clr   in   flush: clears valid, leaves data untouched
//   ld    in   stage advances this cycle (load from upstream)
//   vin   in   upstream valid
//   din   in   upstream data
//   vout  out  stage valid
//   dout  out  stage data
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [WIDTH-1:0] dout
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clr) begin
            v_d = 1'b0;
        end else if (ld) begin
            v_d = vin;
            // Bubbles do not overwrite data, so an idle output keeps its last value.
            if (vin) begin
                d_d = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign vout = v_q;
    assign dout = d_q;

endmodule

// File: rtl/elastic_pipe_line.sv
// Stallable, bubble-collapsing register pipeline of DEPTH stages.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   flush      in   synchronous kill of every in-flight entry
//   in_valid   in   upstream presents in_data
//   in_ready   out  pipe accepts in_data this cycle
//   in_data    in   upstream data
//   out_valid  out  last stage holds a valid entry
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  last-stage data
//   occupancy  out  number of valid stages
module elastic_pipe_line
    import elastic_pipe_line_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [count_w(DEPTH)-1:0] occupancy
);

    localparam int CNT_W = count_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] occ_q, occ_d;

    // Stage i advances when the output drains or any stage from i to the
    // output is empty; written as a running AND to avoid a self-referencing vector.
    always_comb begin
        logic all_v;
        all_v = 1'b1;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_v  = all_v & v[i];
            adv[i] = out_ready | ~all_v;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             vin_w;
        logic [WIDTH-1:0] din_w;
        if (i == 0) begin : g_first
            assign vin_w = in_valid;
            assign din_w = in_data;
        end else begin : g_rest
            assign vin_w = v[i-1];
            assign din_w = d[i-1];
        end
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .clr  (flush),
            .ld   (adv[i]),
            .vin  (vin_w),
            .din  (din_w),
            .vout (v[i]),
            .dout (d[i])
        );
    end

    assign in_ready  = adv[0] & ~flush & ~rst;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Tracked incrementally so occupancy is a register rather than a popcount tree.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (push && !pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_line.sv
module tb_elastic_pipe_line;
    import elastic_pipe_line_pkg::*;

    localparam int NCFG = 3;

    function automatic int cfg_w(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_d(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int w);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        return m[31:0];
    endfunction

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid    [NCFG];
    logic        out_ready   [NCFG];
    logic        in_ready_w  [NCFG];
    logic        out_valid_w [NCFG];
    logic [31:0] out_data_w  [NCFG];
    logic [31:0] occ_w       [NCFG];

    exp_t exp_q[$];
    exp_t e;
    int   cyc;
    int   cur;
    int   n_chk;
    int   n_pass;

    for (genvar k = 0; k < NCFG; k++) begin : g_dut
        localparam int W = cfg_w(k);
        localparam int D = cfg_d(k);
        logic [W-1:0]          od;
        logic [count_w(D)-1:0] occ;
        elastic_pipe_line #(.WIDTH(W), .DEPTH(D)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready_w[k]),
            .in_data   (in_data[W-1:0]),
            .out_valid (out_valid_w[k]),
            .out_ready (out_ready[k]),
            .out_data  (od),
            .occupancy (occ)
        );
        assign out_data_w[k] = 32'(od);
        assign occ_w[k]      = 32'(occ);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle of inputs just after the edge; at mid-cycle, record an
    // accepted beat as an expected output.
    task automatic drive(input int k, input bit iv, input logic [31:0] dat,
                         input bit ordy, input bit lat);
        @(posedge clk);
        #1;
        in_valid[k]  = iv;
        in_data      = dat;
        out_ready[k] = ordy;
        @(negedge clk);
        if (iv && in_ready_w[k]) exp_q.push_back('{dat & wmask(cfg_w(k)), cyc, lat});
    endtask

    // Output monitor: every output transfer must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid_w[cur] && out_ready[cur]) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output cfg%0d: got 0x%0h, expected nothing", cur, out_data_w[cur]);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data_w[cur], e.data);
                if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(cfg_d(cur)));
            end
        end
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        cur     = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        in_data = 32'h77;
        for (int k = 0; k < NCFG; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        in_valid[0] = 1'b1;

        // Reset with in_valid asserted
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready_w[0]), 32'd0);
        for (int k = 0; k < NCFG; k++) begin
            chk("rst_out_valid", 32'(out_valid_w[k]), 32'd0);
            chk("rst_occupancy", occ_w[k], 32'd0);
            chk("rst_out_data", out_data_w[k], 32'd0);
        end
        rst         = 1'b0;
        in_valid[0] = 1'b0;

        // Streaming 0x01..0x0A, latency 3, no gaps
        for (int v = 1; v <= 10; v++) drive(0, 1'b1, 32'(v), 1'b1, 1'b1);
        repeat (5) drive(0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: fill, stay full and stable, then drain in order
        drive(0, 1'b1, 32'hA1, 1'b0, 1'b0);
        drive(0, 1'b1, 32'hA2, 1'b0, 1'b0);
        drive(0, 1'b1, 32'hA3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 32'hEE, 1'b0, 1'b0);
            chk("full_occupancy", occ_w[0], 32'd3);
            chk("full_in_ready", 32'(in_ready_w[0]), 32'd0);
            chk("full_out_valid", 32'(out_valid_w[0]), 32'd1);
            chk("full_out_data", out_data_w[0], 32'hA1);
        end
        repeat (5) drive(0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Bubble collapse under a stalled output
        drive(0, 1'b1, 32'h11, 1'b0, 1'b0);
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(0, 1'b1, 32'h22, 1'b0, 1'b0);
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("bubble_occupancy", occ_w[0], 32'd2);
        chk("bubble_out_valid", 32'(out_valid_w[0]), 32'd1);
        chk("bubble_out_data", out_data_w[0], 32'h11);
        repeat (5) drive(0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("bubble_drained", 32'(exp_q.size()), 32'd0);

        // Flush with a full pipe: head pops, 0x55 and the rest are dropped
        drive(0, 1'b1, 32'h31, 1'b0, 1'b0);
        drive(0, 1'b1, 32'h32, 1'b0, 1'b0);
        drive(0, 1'b1, 32'h33, 1'b0, 1'b0);
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("preflush_occupancy", occ_w[0], 32'd3);
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b1;
        in_data      = 32'h55;
        out_ready[0] = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready_w[0]), 32'd0);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        in_valid[0] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_occupancy", occ_w[0], 32'd0);
        chk("flush_out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("flush_out_data_kept", out_data_w[0], 32'h31);
        repeat (4) drive(0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Per-configuration: unstalled latency burst, then random valid/ready
        for (int k = 0; k < NCFG; k++) begin
            cur = k;
            for (int i = 0; i < 12; i++) drive(k, 1'b1, $urandom, 1'b1, 1'b1);
            repeat (cfg_d(k) + 3) drive(k, 1'b0, 32'd0, 1'b1, 1'b0);
            for (int i = 0; i < 200; i++)
                drive(k, ($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, 1'b0);
            repeat (cfg_d(k) + 3) drive(k, 1'b0, 32'd0, 1'b1, 1'b0);
            chk("sweep_drained", 32'(exp_q.size()), 32'd0);
            chk("sweep_occupancy", occ_w[k], 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
